// File: rtl/test_pkg.sv
// ============================================================================
// Module      : test_pkg
// Description : Shared types and constants for the nibble-wide Ethernet relay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package test_pkg;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PRE  = 2'd1,
    R_DATA = 2'd2,
    R_DROP = 2'd3
  } rx_state_e;

  typedef enum logic [2:0] {
    T_IDLE = 3'd0,
    T_PRE  = 3'd1,
    T_SFD  = 3'd2,
    T_DATA = 3'd3,
    T_IFG  = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic       last;
    logic [3:0] nib;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/test_nibble_fifo.sv
// ============================================================================
// Module      : nibble_fifo
// Description : Synchronous {last,nibble} FIFO with full/empty/free-count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_fifo
  import test_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  entry_t        wr_data,
  input  logic          rd_en,
  output entry_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   free
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  entry_t        mem [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign free    = DEPTH - count_q;
  assign rd_data = mem[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/test.sv
// ============================================================================
// Module      : test
// Description : MII nibble store-and-forward relay (rx port 1 -> tx port 0).
//               Optional TEST_STATS_EN adds rx/tx/drop frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module test
  import test_pkg::*;
#(
  parameter int FIFO_AW   = 11,
  parameter int MIN_PRE   = 2,
  parameter int MAX_FRAME = 1536,
  parameter int TX_PRE    = 15,
  parameter int IFG_NIB   = 24
) (
  input  logic        rxc,
  input  logic        rst,
  input  logic [3:0]  rxd,
  input  logic        rxdv,
  input  logic        clkin,
  output logic        txc,
  output logic        txen,
  output logic [3:0]  txd
`ifdef TEST_STATS_EN
  ,
  output logic [15:0] rx_frames,
  output logic [15:0] tx_frames,
  output logic [15:0] drop_frames
`endif
);

  localparam int PCW = $clog2(MIN_PRE + 1);
  localparam int RCW = $clog2(MAX_FRAME + 1);
  localparam int TCW = $clog2(((TX_PRE > IFG_NIB) ? TX_PRE : IFG_NIB) + 1);

  localparam logic [PCW-1:0]   MIN_PRE_C  = PCW'(MIN_PRE);
  localparam logic [RCW-1:0]   MAX_LAST_C = RCW'(MAX_FRAME - 1);
  localparam logic [FIFO_AW:0] MAX_FREE_C = (FIFO_AW+1)'(MAX_FRAME);
  localparam logic [TCW-1:0]   TX_PRE_C   = TCW'(TX_PRE - 1);
  localparam logic [TCW-1:0]   IFG_C      = TCW'(IFG_NIB - 1);

  rx_state_e        rx_state_q, rx_state_d;
  logic [PCW-1:0]   pre_cnt_q, pre_cnt_d;
  logic [RCW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  tx_state_e        tx_state_q, tx_state_d;
  logic [TCW-1:0]   cnt_q, cnt_d;
  logic [FIFO_AW:0] pend_q, pend_d;
  logic             txen_q, txen_d;
  logic [3:0]       txd_q, txd_d;

  logic             wr_en, rd_en, frame_done, drop_enter, tx_last;
  entry_t           wr_entry, rd_entry;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_free;
  logic             unused_ok;

  assign txc       = rxc;
  assign txen      = txen_q;
  assign txd       = txd_q;
  assign unused_ok = ^{clkin, fifo_full, fifo_empty};

  nibble_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (rxc),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .free    (fifo_free)
  );

  // Rx: one-nibble hold register lets the final nibble be tagged last on rxdv fall.
  always_comb begin
    rx_state_d = rx_state_q;
    pre_cnt_d  = pre_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    wr_en      = 1'b0;
    wr_entry   = '{last: 1'b0, nib: hold_q};
    frame_done = 1'b0;
    drop_enter = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rxdv && rxd == PRE_NIB) begin
          rx_state_d = R_PRE;
          pre_cnt_d  = PCW'(1);
        end
      end
      R_PRE: begin
        if (!rxdv) begin
          rx_state_d = R_IDLE;
        end else if (rxd == PRE_NIB) begin
          if (pre_cnt_q != MIN_PRE_C) pre_cnt_d = pre_cnt_q + PCW'(1);
        end else if (rxd == SFD_NIB && pre_cnt_q >= MIN_PRE_C && fifo_free >= MAX_FREE_C) begin
          rx_state_d = R_DATA;
          rx_cnt_d   = '0;
          hold_vld_d = 1'b0;
        end else begin
          rx_state_d = R_DROP;
          drop_enter = 1'b1;
        end
      end
      R_DATA: begin
        if (!rxdv) begin
          rx_state_d    = R_IDLE;
          hold_vld_d    = 1'b0;
          wr_en         = hold_vld_q;
          wr_entry.last = 1'b1;
          frame_done    = hold_vld_q;
        end else begin
          wr_en      = hold_vld_q;
          hold_d     = rxd;
          hold_vld_d = 1'b1;
          rx_cnt_d   = rx_cnt_q + RCW'(1);
          if (rx_cnt_q == MAX_LAST_C) begin
            rx_state_d = R_DROP;
            drop_enter = 1'b1;
          end
        end
      end
      R_DROP: begin
        // A truncated frame still owes its final (last-tagged) nibble.
        if (hold_vld_q) begin
          wr_en         = 1'b1;
          wr_entry.last = 1'b1;
          frame_done    = 1'b1;
          hold_vld_d    = 1'b0;
        end
        if (!rxdv) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    cnt_d      = cnt_q;
    rd_en      = 1'b0;
    tx_last    = 1'b0;
    txen_d     = 1'b0;
    txd_d      = 4'h0;
    case (tx_state_q)
      T_IDLE: begin
        if (pend_q != '0 && cnt_q == '0) begin
          tx_state_d = T_PRE;
          cnt_d      = TX_PRE_C;
        end
      end
      T_PRE: begin
        txen_d = 1'b1;
        txd_d  = PRE_NIB;
        if (cnt_q == '0) tx_state_d = T_SFD;
        else             cnt_d      = cnt_q - TCW'(1);
      end
      T_SFD: begin
        txen_d     = 1'b1;
        txd_d      = SFD_NIB;
        tx_state_d = T_DATA;
      end
      T_DATA: begin
        rd_en  = 1'b1;
        txen_d = 1'b1;
        txd_d  = rd_entry.nib;
        if (rd_entry.last) begin
          tx_last    = 1'b1;
          tx_state_d = T_IFG;
          cnt_d      = IFG_C;
        end
      end
      T_IFG: begin
        if (cnt_q == '0) tx_state_d = T_IDLE;
        else             cnt_d      = cnt_q - TCW'(1);
      end
      default: tx_state_d = T_IDLE;
    endcase
    pend_d = pend_q + (FIFO_AW+1)'(frame_done) - (FIFO_AW+1)'(tx_last);
  end

  always_ff @(posedge rxc) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      pre_cnt_q  <= '0;
      rx_cnt_q   <= '0;
      hold_q     <= 4'h0;
      hold_vld_q <= 1'b0;
      tx_state_q <= T_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      txen_q     <= 1'b0;
      txd_q      <= 4'h0;
    end else begin
      rx_state_q <= rx_state_d;
      pre_cnt_q  <= pre_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tx_state_q <= tx_state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      txen_q     <= txen_d;
      txd_q      <= txd_d;
    end
  end

`ifdef TEST_STATS_EN
  logic [15:0] rx_frames_q, rx_frames_d;
  logic [15:0] tx_frames_q, tx_frames_d;
  logic [15:0] drop_frames_q, drop_frames_d;

  always_comb begin
    rx_frames_d   = rx_frames_q + 16'(frame_done);
    tx_frames_d   = tx_frames_q + 16'(tx_last);
    drop_frames_d = drop_frames_q + 16'(drop_enter);
  end

  always_ff @(posedge rxc) begin
    if (rst) begin
      rx_frames_q   <= '0;
      tx_frames_q   <= '0;
      drop_frames_q <= '0;
    end else begin
      rx_frames_q   <= rx_frames_d;
      tx_frames_q   <= tx_frames_d;
      drop_frames_q <= drop_frames_d;
    end
  end

  assign rx_frames   = rx_frames_q;
  assign tx_frames   = tx_frames_q;
  assign drop_frames = drop_frames_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_test.sv
// ============================================================================
// Module      : tb_test
// Description : Directed self-checking bench for the nibble relay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_test;

  logic       rxc   = 1'b0;
  logic       clkin = 1'b0;
  logic       rst   = 1'b1;
  logic       rxdv  = 1'b0;
  logic [3:0] rxd   = 4'h0;
  logic       txc;
  logic       txen;
  logic [3:0] txd;
`ifdef TEST_STATS_EN
  logic [15:0] rx_frames, tx_frames, drop_frames;
`endif

  test dut (
    .rxc         (rxc),
    .rst         (rst),
    .rxd         (rxd),
    .rxdv        (rxdv),
    .clkin       (clkin),
    .txc         (txc),
    .txen        (txen),
    .txd         (txd)
`ifdef TEST_STATS_EN
    ,
    .rx_frames   (rx_frames),
    .tx_frames   (tx_frames),
    .drop_frames (drop_frames)
`endif
  );

  always #4  rxc   = ~rxc;
  always #10 clkin = ~clkin;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tx monitor: collects each txen burst and checks it against the expected frame.
  int         cyc         = 0;
  int         frames_seen = 0;
  int         rise_cyc    = 0;
  int         drop_cyc    = 0;
  int         gap         = 0;
  int         min_gap     = 1000000;
  int         idle_bad    = 0;
  int         flen, ferr;
  int         exp_len     = 0;
  logic [3:0] exp_last    = 4'h0;
  logic [3:0] exp_nib;
  logic       in_frame    = 1'b0;
  logic       prev_valid  = 1'b0;
  logic       abort       = 1'b0;
  logic [3:0] fbuf[$];

  always begin
    @(posedge rxc);
    cyc++;
    #2;
    if (txen === 1'b1) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        rise_cyc = cyc;
        fbuf.delete();
        if (prev_valid && gap < min_gap) min_gap = gap;
      end
      fbuf.push_back(txd);
    end else begin
      if (txd !== 4'h0) idle_bad++;
      if (in_frame) begin
        in_frame = 1'b0;
        gap      = 1;
        if (abort) begin
          abort      = 1'b0;
          prev_valid = 1'b0;
        end else begin
          flen = fbuf.size();
          ferr = 0;
          for (int i = 0; i < flen; i++) begin
            if (i < 15)       exp_nib = 4'h5;
            else if (i == 15) exp_nib = 4'hD;
            else              exp_nib = 4'(14 + i - 16);
            if (fbuf[i] !== exp_nib) ferr++;
          end
          chk("frame_len", flen, 16 + exp_len);
          chk("frame_nib_errs", ferr, 0);
          chk("frame_last_nib", fbuf[flen-1], exp_last);
          frames_seen++;
          prev_valid = 1'b1;
        end
      end else begin
        gap++;
      end
    end
  end

  task automatic send_frame(input int npre, input int nlen);
    @(negedge rxc); rxdv = 1'b1; rxd = 4'h0;
    for (int i = 0; i < npre; i++) begin @(negedge rxc); rxd = 4'h5; end
    @(negedge rxc); rxd = 4'hD;
    for (int i = 0; i < nlen; i++) begin @(negedge rxc); rxd = 4'(14 + i); end
    @(negedge rxc); rxdv = 1'b0; rxd = 4'h0; drop_cyc = cyc;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_seen < target && n < 3000) begin @(negedge rxc); n++; end
    chk("frames_seen", frames_seen, target);
  endtask

  int d1;

  initial begin
    repeat (5) begin
      @(posedge rxc); #2;
      chk("rst_txen", txen, 0);
      chk("rst_txd", txd, 0);
    end
    chk("txc_high", txc, 1);
    @(negedge rxc); #2;
    chk("txc_low", txc, 0);
    @(negedge rxc); rst = 1'b0;

    exp_len = 999; exp_last = 4'h4;
    send_frame(15, 999);
    wait_frames(1);
    chk("latency_first", rise_cyc - drop_cyc, 3);

    for (int k = 0; k < 10; k++) begin
      repeat (1000) @(negedge rxc);
      send_frame(15, 999);
      wait_frames(2 + k);
      chk("latency_repeat", rise_cyc - drop_cyc, 3);
    end

    // One preamble nibble is below the minimum of two: frame must vanish.
    send_frame(1, 20);
    repeat (200) @(negedge rxc);
    chk("short_pre_dropped", frames_seen, 11);
`ifdef TEST_STATS_EN
    chk("drop_after_short", drop_frames, 1);
`endif

    // Two back-to-back frames at exactly MIN_PRE: the second waits out the IFG.
    exp_len = 30; exp_last = 4'hB;
    send_frame(2, 30);
    d1 = drop_cyc;
    send_frame(2, 30);
    wait_frames(12);
    chk("latency_min_pre", rise_cyc - d1, 3);
    wait_frames(13);

    exp_len = 1536; exp_last = 4'hD;
    send_frame(15, 1546);
    wait_frames(14);
    chk("min_ifg_ge_24", (min_gap >= 24), 1);
`ifdef TEST_STATS_EN
    chk("rx_frames", rx_frames, 14);
    chk("tx_frames", tx_frames, 14);
    chk("drop_frames", drop_frames, 2);
`endif

    // Reset in the middle of a payload, then relay a fresh frame.
    exp_len = 999; exp_last = 4'h4;
    send_frame(15, 999);
    begin
      int n = 0;
      while (txen !== 1'b1 && n < 3000) begin @(negedge rxc); n++; end
      chk("txen_before_abort", txen, 1);
    end
    repeat (40) @(negedge rxc);
    rst = 1'b1; abort = 1'b1;
    @(posedge rxc); #3;
    chk("txen_after_rst", txen, 0);
    chk("txd_after_rst", txd, 0);
    @(negedge rxc);
    @(negedge rxc); rst = 1'b0;
    send_frame(15, 999);
    wait_frames(15);
    chk("latency_after_rst", rise_cyc - drop_cyc, 3);
`ifdef TEST_STATS_EN
    chk("rx_frames_post_rst", rx_frames, 1);
    chk("tx_frames_post_rst", tx_frames, 1);
    chk("drop_frames_post_rst", drop_frames, 0);
`endif

    repeat (40) @(negedge rxc);
    chk("txd_zero_when_idle", idle_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
